// File: rtl/mp_add_sequencer_pkg.sv
// mp_add_sequencer_pkg: shared word width and FSM state encoding
package mp_add_sequencer_pkg;
  localparam int WORD_W = 64;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
endpackage

// File: rtl/mp_add_sequencer_cla.sv
// cla_64bit: 64-bit adder built from 4-bit carry-lookahead groups
module cla_64bit
  import mp_add_sequencer_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);
  logic [WORD_W-1:0] g, p;
  logic [WORD_W:0]   cv;
  assign g = a & b;
  assign p = a ^ b;
  // lookahead carries inside each 4-bit group, group carry feeds the next
  always_comb begin
    cv    = '0;
    cv[0] = cin;
    for (int k = 0; k < WORD_W; k += 4) begin
      cv[k+1] = g[k] | (p[k] & cv[k]);
      cv[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & cv[k]);
      cv[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
              | (p[k+2] & p[k+1] & p[k] & cv[k]);
      cv[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
              | (p[k+3] & p[k+2] & p[k+1] & g[k])
              | (p[k+3] & p[k+2] & p[k+1] & p[k] & cv[k]);
    end
  end
  assign sum  = p ^ cv[WORD_W-1:0];
  assign cout = cv[WORD_W];
endmodule

// File: rtl/mp_add_sequencer.sv
// mp_add_sequencer: streams word pairs through one adder, carrying between words
module mp_add_sequencer
  import mp_add_sequencer_pkg::*;
#(
  parameter int MAX_WORDS = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              cin_init,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout,
  output logic [7:0]        out_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);
  logic [1:0]        state_q, state_d;
  logic              carry_q, valid_q, last_q, cout_q, err_q;
  logic [7:0]        cnt_q, idx_q;
  logic [WORD_W-1:0] sum_q, s;
  logic              c, acc, top, fin;

  cla_64bit u_cla (.a(in_a), .b(in_b), .cin(carry_q), .sum(s), .cout(c));

  assign in_ready  = (state_q == S_RUN) && (!valid_q || out_ready);
  assign acc       = in_valid && in_ready;
  assign top       = cnt_q == 8'(MAX_WORDS - 1);
  assign fin       = in_last || top;
  assign done      = (state_q == S_FLUSH) && valid_q && out_ready;
  assign busy      = state_q != S_IDLE;
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_last  = last_q;
  assign out_cout  = cout_q;
  assign out_idx   = idx_q;
  assign err       = err_q;

  // FSM: IDLE -> RUN on start, RUN -> FLUSH on final word, FLUSH -> IDLE when it drains
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE && start) state_d = S_RUN;
    if (state_q == S_RUN && acc && fin) state_d = S_FLUSH;
    if (done) state_d = S_IDLE;
  end

  // carry chain, word counter and the single-entry output register
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        carry_q <= cin_init;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end
      if (acc) begin
        sum_q   <= s;
        idx_q   <= cnt_q;
        last_q  <= fin;
        cout_q  <= c;
        valid_q <= 1'b1;
        carry_q <= c;
        cnt_q   <= cnt_q + 8'd1;
        if (top && !in_last) err_q <= 1'b1;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/mp_add_sequencer.md
MP_ADD_SEQUENCER -- requirements
Module: mp_add_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 16, giving the maximum number of 64-bit words per multi-precision operation (range 2..255).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: begins an operation when sampled high in IDLE.
REQ-005 The block SHALL have port cin_init, input, 1 bit: carry-in for word 0, sampled with start.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operand word pair present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts the operand word pair this cycle.
REQ-008 The block SHALL have port in_a, input, 64 bits: operand A word, least-significant word first.
REQ-009 The block SHALL have port in_b, input, 64 bits: operand B word.
REQ-010 The block SHALL have port in_last, input, 1 bit: marks the final word pair of the operation.
REQ-011 The block SHALL have port out_valid, output, 1 bit: sum word held in output register.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream consumes the sum word.
REQ-013 The block SHALL have port out_sum, output, 64 bits: sum word.
REQ-014 The block SHALL have port out_last, output, 1 bit: the sum word is the final word.
REQ-015 The block SHALL have port out_cout, output, 1 bit: carry out of the final word; valid only with out_last.
REQ-016 The block SHALL have port out_idx, output, 8 bits: index of the sum word (0-based).
REQ-017 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-018 The block SHALL have port done, output, 1 bit: one-cycle pulse when the operation completes.
REQ-019 The block SHALL have port err, output, 1 bit: sticky overrun flag, cleared by the next accepted start.

Function
REQ-020 The block SHALL implement FSM states IDLE, RUN and FLUSH.
REQ-021 In IDLE with start=1, the block SHALL load the carry register from cin_init, clear the word counter and err, and enter RUN next cycle.
REQ-022 The block SHALL ignore start while in RUN or FLUSH.
REQ-023 The block SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-024 A word SHALL be accepted only when in_valid && in_ready.
REQ-025 On acceptance the block SHALL compute {c,s} = in_a + in_b + carry in one 65-bit addition, load s, counter, in_last and c into the output register, set out_valid, update carry to c, and increment the counter.
REQ-026 Latency from acceptance to out_valid SHALL be exactly 1 cycle.
REQ-027 Throughput SHALL be 1 word per cycle while out_ready=1.
REQ-028 out_valid SHALL clear on out_valid && out_ready unless a new word is accepted in the same cycle, in which case the register reloads.
REQ-029 Output register contents SHALL hold stable while out_valid && !out_ready.
REQ-030 The block SHALL move from RUN to FLUSH on acceptance of a word with in_last=1, or of word index MAX_WORDS-1.
REQ-031 When the word at index MAX_WORDS-1 is accepted with in_last=0, the block SHALL set err=1 and force out_last=1.
REQ-032 In FLUSH the block SHALL wait until the final word handshakes, then pulse done for one cycle in that cycle and enter IDLE.
REQ-033 A single-word operation (in_last on word 0) SHALL be legal.
REQ-034 out_cout SHALL equal the carry out of the final word.

Reset
REQ-035 While reset is high at a clock edge, the block SHALL enter IDLE and drive in_ready=0, out_valid=0, out_sum=0, out_last=0, out_cout=0, out_idx=0, busy=0, done=0, err=0, with carry and counter cleared.
REQ-036 Reset mid-operation SHALL discard any buffered word without emitting it.
REQ-037 Reset SHALL take priority over start and over all handshakes.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding and the word width constant (64).
REQ-039 The 64-bit addition SHALL use one instance of the existing sub-module cla_64bit (a, b, cin, sum, cout), and no other adder.

Verification
REQ-040 The bench SHALL check: 2-word add, A={0x1,0xFFFF_FFFF_FFFF_FFFF}, B={0x0,0x1}, cin=0 -> words 0x0 then 0x2, out_cout=0, done one cycle after word 1 handshakes.
REQ-041 The bench SHALL check: 1 word 0xFFFF_FFFF_FFFF_FFFF + 0x0 with cin=1 -> out_sum=0, out_last=1, out_cout=1.
REQ-042 The bench SHALL check: out_ready=0 for 5 cycles with word 0 buffered -> in_ready=0 and out_sum stable, then 1 word/cycle once out_ready=1.
REQ-043 The bench SHALL check: MAX_WORDS=4 with 4 words and no in_last -> word 3 has out_last=1, err=1, FSM returns to IDLE, and the next start clears err.
REQ-044 The bench SHALL check: reset asserted in RUN after 1 accepted word -> next cycle out_valid=0, busy=0, and no done pulse.
REQ-045 The bench SHALL check: 200 random 4-word operations compared against a 256-bit reference sum -> zero mismatches.
